sha256_golden_nonce_tracker: RTL
================================

// Module: sha256_golden_nonce_tracker
// PURPOSE
//  Sits after the final 32-bit hash pipe; issues one nonce per clock to the upstream data builder.
//  Delay-matches each nonce against the returning byte-swapped hash word and flags winners.
//  Queues winning ("golden") nonces in a small FWFT FIFO drained by the host interface over valid/ready.
// PARAMETERS
//  LATENCY     190  clocks from nonce_out issue to matching hash_in word; must be >= 2
//  FIFO_DEPTH  4    golden-nonce FIFO entries; power of two, 2..16
// PORTS
//  clk            in   1   single clock, all logic on rising edge
//  rst            in   1   synchronous, active-high reset
//  start          in   1   1-cycle pulse: load nonce_start, flush in-flight tracking
//  nonce_start    in   32  first nonce after start
//  run            in   1   1 = issue a nonce this cycle
//  nonce_out      out  32  nonce presented upstream this cycle
//  nonce_vld      out  1   nonce_out is consumed this cycle (== run & ~start)
//  hash_in        in   32  final hash word from the pipe, aligned LATENCY cycles after issue
//  golden_valid   out  1   FIFO non-empty; golden_nonce is valid
//  golden_nonce   out  32  head-of-FIFO nonce
//  golden_ready   in   1   pop head when golden_valid & golden_ready
//  overflow       out  1   sticky: a golden nonce was dropped because the FIFO was full
//  wrapped        out  1   sticky: nonce_out passed 32'hFFFFFFFF -> 0
// BEHAVIOUR
//  Reset
//   - nonce_out=0, check counter=0, tag shift register all 0.
//   - FIFO empty: golden_valid=0, golden_nonce=0.
//   - overflow=0, wrapped=0.
//  Issue
//   - start: nonce_out<=nonce_start, check_nonce<=nonce_start, tag shreg cleared.
//   - start also clears overflow and wrapped; the FIFO is kept.
//   - Otherwise, if run: nonce_out<=nonce_out+1, mod 2^32.
//   - If run and nonce_out==32'hFFFFFFFF: wrapped<=1.
//   - start has priority over run in the same cycle: no increment, and nonce_vld=0.
//  Tracking
//   - LATENCY-bit shift register; bit shifted in = nonce_vld.
//   - Tag bit exits exactly when the matching hash_in is present.
//   - check_nonce increments only on cycles where the exiting tag=1.
//   - check_nonce therefore stays correct across gaps in run.
//   - Cycles with exiting tag=0 ignore hash_in.
//  Hit
//   - hit = exiting tag & (hash_in == 32'h0).
//   - The pushed value is check_nonce before its increment.
//  FIFO
//   - Push on hit; entry visible as golden_valid one clock after the hit cycle.
//   - Pop when golden_valid & golden_ready; next entry (if any) appears the following cycle.
//   - Full & hit & pop in the same cycle: push accepted, occupancy unchanged.
//   - Full & hit & no pop: nonce dropped, overflow<=1, FIFO unchanged.
//   - Empty & pop request: ignored (golden_valid=0).
//   - golden_nonce holds its last value while empty.
//  Mid-run start
//   - In-flight results are discarded: tags cleared, so no stale hits for LATENCY cycles.
//   - FIFO contents survive; the host drains them.
//  rst mid-operation: every state returns to its reset value on the next edge, FIFO contents are lost.
// CONFIGURATION
//  TARGET_CMP_EN defined
//   - Adds input target[31:0].
//   - hit = exiting tag & (hash_in <= target), unsigned compare.
//   - target is sampled combinationally in the hit cycle.
//  TARGET_CMP_EN undefined
//   - No target port; hit requires hash_in == 0, as above.
// TESTING
//  1. rst, start nonce_start=32'h100, run=1 continuously, hash_in=0 only in the cycle matching 32'h105
//     -> one pop yields 32'h105; no other golden_valid.
//  2. run toggled 1,0,0,1,... with hits injected for the 1st and 3rd issued nonces (start=32'h0)
//     -> pops return 32'h0 then 32'h2 (gaps do not skew the nonce).
//  3. golden_ready=0, 5 hits at FIFO_DEPTH=4
//     -> 4 queued in order, 5th dropped, overflow=1.
//     -> next start clears overflow; the 4 entries still drain.
//  4. Full FIFO, hit and pop in the same cycle -> new nonce accepted, count stays 4, overflow stays 0.
//  5. start=32'hFFFFFFFE, run=1 -> nonce_out FFFFFFFE, FFFFFFFF, 0; wrapped=1 on the third edge.
//     -> hit on the wrapped slot reports 32'h0.
//  6. Hit in flight, start re-issued LATENCY/2 cycles later -> stale hit ignored, no golden_valid;
//     TARGET_CMP_EN build: target=32'h0000FFFF, hash_in=32'h00001234 -> hit.

Source files
------------

// File: rtl/sha256_golden_nonce_tracker_if.sv
// Host-side golden-nonce drain bus: FWFT head with valid/ready pop.
interface sha256_golden_nonce_tracker_if;
    logic        golden_valid;
    logic [31:0] golden_nonce;
    logic        golden_ready;

    modport master (
        output golden_valid,
        output golden_nonce,
        input  golden_ready
    );

    modport slave (
        input  golden_valid,
        input  golden_nonce,
        output golden_ready
    );
endinterface

// File: rtl/sha256_golden_nonce_tracker.sv
// Nonce issue, delay-matched hit detection and golden-nonce FWFT FIFO.
// Optional TARGET_CMP_EN: adds target port, hit = hash_in <= target.
module sha256_golden_nonce_tracker #(
    parameter int LATENCY    = 190,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] nonce_start,
    input  logic        run,
    output logic [31:0] nonce_out,
    output logic        nonce_vld,
    input  logic [31:0] hash_in,
`ifdef TARGET_CMP_EN
    input  logic [31:0] target,
`endif
    sha256_golden_nonce_tracker_if.master host,
    output logic        overflow,
    output logic        wrapped
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]        nonce_q;
    logic [31:0]        check_nonce;
    logic [LATENCY-1:0] tags;
    logic               tag_exit;
    logic               hit;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_next;
    logic [AW:0]        count;
    logic [AW:0]        count_next;
    logic [31:0]        mem [FIFO_DEPTH];
    logic [31:0]        head;
    logic               ovf_q;
    logic               wrap_q;

    assign nonce_vld = run & ~start;
    assign nonce_out = nonce_q;
    assign tag_exit  = tags[LATENCY-1];

    // Results leaving the pipe during a start cycle belong to the flushed run.
`ifdef TARGET_CMP_EN
    assign hit = tag_exit & ~start & (hash_in <= target);
`else
    assign hit = tag_exit & ~start & (hash_in == 32'h0);
`endif

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = ~empty & host.golden_ready;
    assign push    = hit & (~full | pop);
    assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= check_nonce;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_q     <= '0;
            check_nonce <= '0;
            tags        <= '0;
            ovf_q       <= 1'b0;
            wrap_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head        <= '0;
        end else begin
            if (start) begin
                nonce_q     <= nonce_start;
                check_nonce <= nonce_start;
                tags        <= '0;
                ovf_q       <= 1'b0;
                wrap_q      <= 1'b0;
            end else begin
                if (run) begin
                    nonce_q <= nonce_q + 32'd1;
                    if (&nonce_q) wrap_q <= 1'b1;
                end
                tags <= {tags[LATENCY-2:0], nonce_vld};
                if (tag_exit) check_nonce <= check_nonce + 32'd1;
                if (hit & full & ~pop) ovf_q <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_next;
            count  <= count_next;
            // Bypass when the new head is the entry being written this edge.
            if (count_next != '0)
                head <= (push && rd_next == wr_ptr) ? check_nonce : mem[rd_next];
        end
    end

    assign host.golden_valid = ~empty;
    assign host.golden_nonce = head;
    assign overflow          = ovf_q;
    assign wrapped           = wrap_q;
endmodule
